serial_pattern_tx: RTL

Parallel-to-serial bit-stream transmitter that drives the single-bit `x` line consumed by the team's "1000" Moore sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake, shifts them out MSB-first at one bit per clock, and fills idle time with 0s. An embedded Moore "1000" tracker produces `exp_y` and `hit_count`, the detector response expected for the transmitted stream, so benches can self-check a downstream detector.

---
 rtl/serial_pattern_pkg.sv | 19 +
 rtl/moore_1000_tracker.sv | 49 ++++
 rtl/serial_pattern_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_pattern_pkg.sv
// Shared types for the serial pattern transmitter and its "1000" tracker.
package serial_pattern_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_e;

   // Fixed encodings so detector benches can compare state numbers directly.
   typedef enum logic [2:0] {
      S0    = 3'd0,
      S1    = 3'd1,
      S10   = 3'd2,
      S100  = 3'd3,
      S1000 = 3'd4
   } trk_state_e;

endpackage

// File: rtl/moore_1000_tracker.sv
// Golden Moore "1000" detector: follows the serial line and counts entries into S1000.
module moore_1000_tracker
   import serial_pattern_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       x,
   output logic       exp_y,
   output logic [7:0] hit_count
);

   trk_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = S0;
      cnt_d   = cnt_q;
      if (x) begin
         state_d = S1;
      end else begin
         unique case (state_q)
            S0:      state_d = S0;
            S1:      state_d = S10;
            S10:     state_d = S100;
            S100:    state_d = S1000;
            S1000:   state_d = S0;
            default: state_d = S0;
         endcase
      end
      // S1000 never loops on itself, so every cycle landing there is a fresh entry.
      if (state_d == S1000) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   assign exp_y     = (state_q == S1000);
   assign hit_count = cnt_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: words in over valid/ready, MSB-first bits out on x, idle zeros between.
module serial_pattern_tx
   import serial_pattern_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid,
   output logic             ready,
   output logic             x,
   output logic             busy,
   output logic             done,
   output logic             exp_y,
   output logic [7:0]       hit_count
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   tx_state_e        state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
   logic [GAP_W-1:0] gapcnt_q, gapcnt_d;
   logic             x_q, x_d;
   logic             last_bit;
   logic             accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         gapcnt_q <= '0;
         x_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         gapcnt_q <= gapcnt_d;
         x_q      <= x_d;
      end
   end

   // shreg_q holds the bits still to be sent; the bit currently on the line lives in x_q.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      gapcnt_d = gapcnt_q;
      x_d      = 1'b0;
      last_bit = (state_q == ST_SHIFT) && (bitcnt_q == '0);
      ready    = (state_q == ST_IDLE) || (last_bit && (GAP == 0));
      accept   = valid && ready;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            if (bitcnt_q != '0) begin
               x_d      = shreg_q[WIDTH-1];
               shreg_d  = shreg_q << 1;
               bitcnt_d = bitcnt_q - 1'b1;
            end else if (GAP > 0) begin
               state_d  = ST_GAP;
               gapcnt_d = GAP_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GAP: begin
            if (gapcnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               gapcnt_d = gapcnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new word overrides the idle/shift-end decision, giving seamless back-to-back frames.
      if (accept) begin
         state_d  = ST_SHIFT;
         x_d      = data_in[WIDTH-1];
         shreg_d  = data_in << 1;
         bitcnt_d = BIT_LOAD;
      end
   end

   assign x    = x_q;
   assign busy = (state_q != ST_IDLE);
   assign done = last_bit;

   moore_1000_tracker u_tracker (
      .clk       (clk),
      .rst       (rst),
      .x         (x_q),
      .exp_y     (exp_y),
      .hit_count (hit_count)
   );

endmodule
